// File: rtl/fir_tdm_controller.sv
// fir_tdm_controller: time-multiplexed FIR sequencer.
// One shared MAC walks the delay line, one tap per clock.
module fir_tdm_controller #(
  parameter int N1   = 8,
  parameter int N2   = 16,
  parameter int N3   = 32,
  parameter int TAPS = 8,
  localparam int AW  = $clog2(TAPS)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 coef_we,
  input  logic [AW-1:0]        coef_addr,
  input  logic signed [N1-1:0] coef_wdata,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [N2-1:0] input_data,
  output logic                 out_valid,
  output logic signed [N3-1:0] filtered_data,
  output logic                 busy
);

  localparam int PW = N1 + N2;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

  typedef enum logic {IDLE, MAC} state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        k_q, k_d;
  logic signed [N3-1:0] acc_q, acc_d;
  logic signed [N3-1:0] fd_q, fd_d;
  logic                 ov_q, ov_d;
  logic signed [N2-1:0] smp_q [TAPS];
  logic signed [N2-1:0] smp_d [TAPS];
  logic signed [N1-1:0] coef_q [TAPS];
  logic signed [N1-1:0] coef_d [TAPS];

  logic [DEPTH-1:0]     addr_ok;
  logic signed [PW-1:0] prod;
  logic signed [N3-1:0] term;
  logic signed [N3-1:0] sum;

  // Addresses past the last tap exist only when TAPS is not a power of 2.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      addr_ok[i] = (i < TAPS);
    end
  end

  assign prod = PW'(coef_q[k_q]) * PW'(smp_q[k_q]);
  assign term = N3'(prod);
  assign sum  = acc_q + term;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    acc_d   = acc_q;
    fd_d    = fd_q;
    ov_d    = 1'b0;
    smp_d   = smp_q;
    coef_d  = coef_q;
    if (state_q == IDLE && coef_we && addr_ok[coef_addr]) begin
      coef_d[coef_addr] = coef_wdata;
    end
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          smp_d[0] = input_data;
          for (int i = 1; i < TAPS; i++) begin
            smp_d[i] = smp_q[i-1];
          end
          acc_d   = '0;
          k_d     = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = sum;
        k_d   = k_q + 1'b1;
        if (k_q == LAST) begin
          fd_d    = sum;
          ov_d    = 1'b1;
          k_d     = '0;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      k_q     <= '0;
      acc_q   <= '0;
      fd_q    <= '0;
      ov_q    <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        smp_q[i]  <= '0;
        coef_q[i] <= N1'(16);
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      fd_q    <= fd_d;
      ov_q    <= ov_d;
      smp_q   <= smp_d;
      coef_q  <= coef_d;
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign busy          = ~in_ready;
  assign out_valid     = ov_q;
  assign filtered_data = fd_q;

endmodule

// File: tb/tb_fir_tdm_controller.sv
// tb_fir_tdm_controller: scoreboard bench for the TDM FIR sequencer.
// Directed vectors with hand-computed results.
module tb_fir_tdm_controller;

  logic               CLK = 1'b0;
  logic               RST = 1'b1;
  logic               coef_we = 1'b0;
  logic [2:0]         coef_addr = '0;
  logic signed [7:0]  coef_wdata = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] input_data = '0;
  logic               out_valid;
  logic signed [31:0] filtered_data;
  logic               busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int low_run = 0;
  bit chk_run = 1'b1;

  typedef struct {
    logic signed [31:0] v;
    int                 acc;
  } exp_t;

  exp_t sb_q[$];

  fir_tdm_controller #(
    .N1(8), .N2(16), .N3(32), .TAPS(8)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .coef_we(coef_we),
    .coef_addr(coef_addr),
    .coef_wdata(coef_wdata),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .input_data(input_data),
    .out_valid(out_valid),
    .filtered_data(filtered_data),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: pops the scoreboard on each output pulse.
  always @(negedge CLK) begin
    exp_t e;
    checks++;
    if (busy !== !in_ready) begin
      failures++;
      $display("FAIL busy_vs_ready busy=%0b in_ready=%0b", busy, in_ready);
    end
    if (out_valid === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_out_valid got=%0d required=no pulse",
                 filtered_data);
      end else begin
        e = sb_q.pop_front();
        if (filtered_data !== e.v) begin
          failures++;
          $display("FAIL out_value got=%0d required=%0d", filtered_data, e.v);
        end
        checks++;
        if (cyc - e.acc != 8) begin
          failures++;
          $display("FAIL out_latency got=%0d required=8", cyc - e.acc);
        end
      end
    end
    if (in_ready === 1'b1) begin
      if (chk_run && low_run != 0) begin
        checks++;
        if (low_run != 8) begin
          failures++;
          $display("FAIL ready_low_run got=%0d required=8", low_run);
        end
      end
      low_run = 0;
    end else begin
      low_run++;
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 40) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout in_ready=%0b required=1", in_ready);
    end
  endtask

  task automatic send(input logic signed [15:0] d,
                      input logic signed [31:0] e,
                      input bit chk,
                      input bit cw = 1'b0,
                      input logic [2:0] ca = 3'd0,
                      input logic signed [7:0] cd = 8'sd0);
    @(negedge CLK);
    wait_ready();
    in_valid   = 1'b1;
    input_data = d;
    coef_we    = cw;
    coef_addr  = ca;
    coef_wdata = cd;
    if (chk) sb_q.push_back('{v: e, acc: cyc + 1});
    @(negedge CLK);
    in_valid = 1'b0;
    coef_we  = 1'b0;
  endtask

  task automatic write_coef(input logic [2:0] a,
                            input logic signed [7:0] v,
                            input bit idle);
    @(negedge CLK);
    if (idle) wait_ready();
    coef_we    = 1'b1;
    coef_addr  = a;
    coef_wdata = v;
    @(negedge CLK);
    coef_we = 1'b0;
  endtask

  initial begin
    int hv [8];
    int c;
    int n;
    hv = '{16, 22, 28, 34, 40, 37, 24, 0};

    repeat (2) @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 ||
          filtered_data !== 32'sd0) begin
        failures++;
        $display("FAIL idle_reset rdy=%0b busy=%0b ov=%0b fd=%0d required 1/0/0/0",
                 in_ready, busy, out_valid, filtered_data);
      end
    end

    // Impulse through default coefficients.
    send(16'sd100, 32'sd1600, 1'b1);
    for (int i = 0; i < 7; i++) send(16'sd0, 32'sd1600, 1'b1);
    send(16'sd0, 32'sd0, 1'b1);
    send(16'sd0, 32'sd0, 1'b1);

    for (int k = 0; k < 8; k++) write_coef(3'(k), 8'(k + 1), 1'b1);
    send(16'sd1, 32'sd1, 1'b1);
    send(16'sd2, 32'sd4, 1'b1);
    send(16'sd3, 32'sd10, 1'b1);

    // Held in_valid flushes the line: one acceptance per 9 cycles.
    @(negedge CLK);
    wait_ready();
    in_valid   = 1'b1;
    input_data = 16'sd0;
    c = cyc;
    for (int j = 0; j < 8; j++) sb_q.push_back('{v: hv[j], acc: c + 1 + 9 * j});
    repeat (72) @(negedge CLK);
    in_valid = 1'b0;

    for (int k = 1; k < 8; k++) write_coef(3'(k), -8'sd128, 1'b1);
    send(-16'sd32768, 32'sd4194304, 1'b1, 1'b1, 3'd0, -8'sd128);
    for (int j = 2; j <= 8; j++) send(-16'sd32768, 32'(4194304 * j), 1'b1);

    // Write during MAC must be dropped.
    send(16'sd1, 32'sd29360000, 1'b1);
    write_coef(3'd0, 8'sd0, 1'b0);
    send(16'sd1, 32'sd25165568, 1'b1);

    chk_run = 1'b0;
    send(16'sd7, 32'sd0, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 ||
        filtered_data !== 32'sd0) begin
      failures++;
      $display("FAIL mid_reset rdy=%0b busy=%0b ov=%0b fd=%0d required 1/0/0/0",
               in_ready, busy, out_valid, filtered_data);
    end
    @(negedge CLK);
    chk_run = 1'b1;
    send(16'sd50, 32'sd800, 1'b1);

    n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end
    repeat (12) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
